// File: rtl/vme_pkg.sv
// vme_pkg: shared types, register window bounds and select helpers for the VME slave sequencer.
package vme_pkg;

    localparam int NSEL = 13;

    localparam logic [15:0] REG_FIRST = 16'h7C80;
    localparam logic [15:0] REG_LAST  = 16'h7CA4;

    typedef enum logic [2:0] {IDLE, DECODE, WR, RD, ACK, RELEASE, NOMATCH} state_e;

    function automatic logic is_onehot(input logic [NSEL-1:0] v);
        return v != '0 && (v & (v - NSEL'(1))) == '0;
    endfunction

endpackage

// File: rtl/vme_slave_ctrl_if.sv
// vme_slave_ctrl_if: VME transceiver side and register bank side of the slave sequencer.
interface vme_slave_ctrl_if import vme_pkg::*;;
    logic            as_n, ds0_n, ds1_n, write_n;
    logic [15:0]     addr, data_in, data_out;
    logic [NSEL-1:0] sel, reg_sel;
    logic            data_oe, dtack_n, berr_n, reg_wr, reg_rd, busy;
    logic [15:0]     reg_wdata, reg_rdata;

    modport slave (
        input  as_n, ds0_n, ds1_n, write_n, addr, data_in, sel, reg_rdata,
        output data_out, data_oe, dtack_n, berr_n, reg_wr, reg_rd, reg_sel, reg_wdata, busy
    );

    modport master (
        output as_n, ds0_n, ds1_n, write_n, addr, data_in, sel, reg_rdata,
        input  data_out, data_oe, dtack_n, berr_n, reg_wr, reg_rd, reg_sel, reg_wdata, busy
    );
endinterface

// File: rtl/vme_sync.sv
// vme_sync: N-stage synchroniser for an active-low async strobe; resets to the inactive level.
module vme_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ff_q <= '1;
        else       ff_q <= {ff_q[N-2:0], d_i};
    end

    assign q_o = ff_q[N-1];
endmodule

// File: rtl/vme_slave_ctrl.sv
// vme_slave_ctrl: VME A16/D16 slave cycle sequencer for the 0x7C80-0x7CA4 register window.
// Define VME_BERR_EN to drive BERR_N on unmatched selects and byte accesses.
module vme_slave_ctrl import vme_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    vme_slave_ctrl_if.slave bus
);
    state_e          state_q, state_d;
    logic            as_s, ds0_s, ds1_s, ds_both, ds_none;
    logic [NSEL-1:0] sel_q;
    logic            wr_q;
    logic [15:0]     addr_q, wdata_q, dout_q;
    logic [2:0]      cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] warm_q;
    logic            armed_q, armed_d;
    logic            dtack_n_q, dtack_n_d, oe_q, oe_d, reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, busy_q, busy_d;
`ifdef VME_BERR_EN
    logic            ds_one, byte_q, berr_n_q, berr_n_d;
`endif

    vme_sync #(.N(SYNC_STAGES)) u_as  (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.as_n),  .q_o(as_s));
    vme_sync #(.N(SYNC_STAGES)) u_ds0 (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.ds0_n), .q_o(ds0_s));
    vme_sync #(.N(SYNC_STAGES)) u_ds1 (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.ds1_n), .q_o(ds1_s));

    assign ds_both = !ds0_s && !ds1_s;
    assign ds_none = ds0_s && ds1_s;
`ifdef VME_BERR_EN
    assign ds_one  = ds0_s ^ ds1_s;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            wr_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            cnt_q     <= '0;
            warm_q    <= '0;
            armed_q   <= 1'b0;
            dtack_n_q <= 1'b1;
            oe_q      <= 1'b0;
            reg_wr_q  <= 1'b0;
            reg_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef VME_BERR_EN
            byte_q    <= 1'b0;
            berr_n_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            if (state_q == IDLE && state_d == DECODE) begin
                addr_q  <= bus.addr;
                sel_q   <= bus.sel;
                wr_q    <= bus.write_n;
                wdata_q <= bus.data_in;
            end
            if (state_q == RD && state_d == ACK) dout_q <= bus.reg_rdata;
            cnt_q     <= cnt_d;
            warm_q    <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            armed_q   <= armed_d;
            dtack_n_q <= dtack_n_d;
            oe_q      <= oe_d;
            reg_wr_q  <= reg_wr_d;
            reg_rd_q  <= reg_rd_d;
            busy_q    <= busy_d;
`ifdef VME_BERR_EN
            byte_q    <= !as_s && ds_one;
            berr_n_q  <= berr_n_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && !as_s && ds_both) state_d = DECODE;
`ifdef VME_BERR_EN
                     else if (armed_q && !as_s && ds_one && byte_q) state_d = NOMATCH;
`endif
            DECODE:  state_d = as_s ? IDLE :
                               !(is_onehot(sel_q) && addr_q >= REG_FIRST && addr_q <= REG_LAST) ? NOMATCH :
                               wr_q ? RD : WR;
            WR:      state_d = ACK;
            RD:      state_d = cnt_q == 3'(RD_LAT) ? ACK : RD;
            ACK:     state_d = ds_none ? RELEASE : ACK;
            RELEASE: state_d = IDLE;
            NOMATCH: state_d = (as_s || ds_none) ? IDLE : NOMATCH;
            default: state_d = IDLE;
        endcase
    end

    // Arming waits out the reset value of the synchronisers so a DS held across reset cannot re-trigger.
    always_comb begin
        cnt_d     = (state_q == RD && state_d == RD) ? cnt_q + 3'd1 : 3'd0;
        armed_d   = (state_q == IDLE && state_d != IDLE) ? 1'b0 :
                    (warm_q[SYNC_STAGES-1] && ds_none) ? 1'b1 : armed_q;
        dtack_n_d = state_d != ACK;
        oe_d      = state_d == ACK && (state_q == RD || oe_q);
        reg_wr_d  = state_d == WR;
        reg_rd_d  = state_d == RD && state_q != RD;
        busy_d    = state_d != IDLE;
`ifdef VME_BERR_EN
        berr_n_d  = state_d != NOMATCH;
`endif
    end

    assign bus.data_out  = dout_q;
    assign bus.data_oe   = oe_q;
    assign bus.dtack_n   = dtack_n_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.reg_sel   = sel_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.busy      = busy_q;
`ifdef VME_BERR_EN
    assign bus.berr_n    = berr_n_q;
`else
    assign bus.berr_n    = 1'b1;
`endif
endmodule

// File: tb/tb_vme_slave_ctrl.sv
// tb_vme_slave_ctrl: directed bench for the VME slave sequencer (SYNC_STAGES=2, RD_LAT=1).
module tb_vme_slave_ctrl;
    import vme_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_wr, n_rd, n_ack;
    logic rd_seen = 1'b0;

    always #5 clk = ~clk;

    vme_slave_ctrl_if bus ();

    vme_slave_ctrl #(.SYNC_STAGES(2), .RD_LAT(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register bank model: data valid one cycle after a REG_RD pulse, garbage otherwise.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.reg_rdata = rd_seen ? 16'h1234 : 16'hDEAD;
        rd_seen = bus.reg_rd;
        n_wr  += int'(bus.reg_wr);
        n_rd  += int'(bus.reg_rd);
        n_ack += int'(!bus.dtack_n);
    endtask

    task automatic clr();
        n_wr = 0; n_rd = 0; n_ack = 0;
    endtask

    task automatic bus_idle();
        bus.as_n = 1'b1; bus.ds0_n = 1'b1; bus.ds1_n = 1'b1; bus.write_n = 1'b1;
    endtask

    task automatic vme_cycle(input logic [15:0] a, input logic [NSEL-1:0] s, input logic wr,
                             input logic [15:0] d, input int hold);
        int lat;
        lat = wr ? 5 : 6;
        bus.addr = a; bus.sel = s; bus.write_n = !wr; bus.data_in = d; bus.as_n = 1'b0;
        repeat (3) tick();
        clr();
        bus.ds0_n = 1'b0; bus.ds1_n = 1'b0;
        repeat (lat - 1) tick();
        chk("dtack_before_lat", 32'(bus.dtack_n), 32'd1);
        chk("reg_sel", 32'(bus.reg_sel), 32'(s));
        tick();
        chk("dtack_at_lat", 32'(bus.dtack_n), 32'd0);
        chk("data_oe_at_ack", 32'(bus.data_oe), 32'(!wr));
        if (!wr) chk("data_out", 32'(bus.data_out), 32'h1234);
        if (wr) chk("reg_wdata", 32'(bus.reg_wdata), 32'(d));
        chk("busy_in_ack", 32'(bus.busy), 32'd1);
        repeat (hold) tick();
        chk("ack_cycles", 32'(n_ack), 32'(hold + 1));
        chk("wr_pulses", 32'(n_wr), 32'(wr));
        chk("rd_pulses", 32'(n_rd), 32'(!wr));
        bus_idle();
        repeat (2) tick();
        chk("dtack_held_2_after_ds", 32'(bus.dtack_n), 32'd0);
        tick();
        chk("dtack_rel_3_after_ds", 32'(bus.dtack_n), 32'd1);
        chk("oe_rel_3_after_ds", 32'(bus.data_oe), 32'd0);
        repeat (2) tick();
        chk("busy_after_release", 32'(bus.busy), 32'd0);
        chk("no_extra_wr", 32'(n_wr), 32'(wr));
    endtask

    initial begin
        bus_idle();
        bus.addr = '0; bus.data_in = '0; bus.sel = '0; bus.reg_rdata = 16'hDEAD;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_dtack_n", 32'(bus.dtack_n), 32'd1);
        chk("rst_berr_n", 32'(bus.berr_n), 32'd1);
        chk("rst_data_oe", 32'(bus.data_oe), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_strobes", 32'({bus.reg_wr, bus.reg_rd, bus.busy}), 32'd0);
        chk("rst_reg_sel", 32'(bus.reg_sel), 32'd0);
        chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        vme_cycle(16'h7C84, 13'h004, 1'b1, 16'hA5A5, 0);
        vme_cycle(16'h7CA2, 13'h200, 1'b0, 16'h0000, 0);

        bus.addr = 16'h7C92; bus.sel = '0; bus.write_n = 1'b1; bus.as_n = 1'b0;
        repeat (3) tick();
        clr();
        bus.ds0_n = 1'b0; bus.ds1_n = 1'b0;
        repeat (10) tick();
        chk("nomatch_strobes", 32'(n_wr + n_rd), 32'd0);
        chk("nomatch_no_dtack", 32'(n_ack), 32'd0);
        chk("nomatch_busy", 32'(bus.busy), 32'd1);
`ifdef VME_BERR_EN
        chk("nomatch_berr", 32'(bus.berr_n), 32'd0);
`else
        chk("nomatch_berr", 32'(bus.berr_n), 32'd1);
`endif
        bus_idle();
        repeat (4) tick();
        chk("nomatch_idle", 32'(bus.busy), 32'd0);
        chk("nomatch_berr_rel", 32'(bus.berr_n), 32'd1);

        bus.addr = 16'h7C84; bus.sel = 13'h004; bus.write_n = 1'b0; bus.as_n = 1'b0;
        repeat (3) tick();
        clr();
        bus.ds0_n = 1'b0;
        repeat (20) tick();
        chk("byte_strobes", 32'(n_wr + n_rd), 32'd0);
        chk("byte_no_dtack", 32'(n_ack), 32'd0);
`ifdef VME_BERR_EN
        chk("byte_berr", 32'(bus.berr_n), 32'd0);
`else
        chk("byte_berr", 32'(bus.berr_n), 32'd1);
        chk("byte_idle_waits", 32'(bus.busy), 32'd0);
`endif
        bus_idle();
        repeat (4) tick();

        bus.addr = 16'h7C80; bus.sel = 13'h001; bus.write_n = 1'b0; bus.data_in = 16'h1111; bus.as_n = 1'b0;
        repeat (3) tick();
        bus.ds0_n = 1'b0; bus.ds1_n = 1'b0;
        repeat (5) tick();
        chk("pre_rst_in_ack", 32'(bus.dtack_n), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_dtack", 32'(bus.dtack_n), 32'd1);
        chk("rst_mid_oe", 32'(bus.data_oe), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        clr();
        repeat (6) tick();
        chk("rst_mid_no_restart", 32'(n_wr + n_rd + n_ack), 32'd0);
        bus_idle();
        repeat (4) tick();
        vme_cycle(16'h7C88, 13'h008, 1'b1, 16'h5A5A, 0);

        vme_cycle(16'h7C8C, 13'h010, 1'b1, 16'hC3C3, 49);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vme_slave_ctrl.md
Name: vme_slave_ctrl

Overview:
VME A16/D16 slave cycle sequencer for the board register window at 0x7C80–0x7CA4.
- Synchronises the asynchronous VME strobes and latches address, data and WRITE* at the start of a cycle.
- Consumes the one-hot register selects from the VME address decoder and issues single-cycle register read/write strobes.
- Drives DTACK* and read-data enable per the VME handshake.
- Sits between the VME transceivers and the register bank.

Parameters:
- SYNC_STAGES, 2, flops per strobe synchroniser (min 2).
- RD_LAT, 1, cycles from REG_RD to REG_RDATA valid (0..7).
- NSEL, 13, number of one-hot register selects.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- AS_N  in  1  VME address strobe, async
- DS0_N  in  1  VME data strobe 0, async
- DS1_N  in  1  VME data strobe 1, async
- WRITE_N  in  1  VME write, low = write
- ADDR  in  16  VME address, stable while AS_N low
- DATA_IN  in  16  VME write data
- SEL  in  NSEL  one-hot register select from the address decoder, combinational on ADDR
- DATA_OUT  out  16  read data to transceivers
- DATA_OE  out  1  read-data transceiver enable
- DTACK_N  out  1  data acknowledge
- BERR_N  out  1  bus error; only driven with VME_BERR_EN, else tied 1
- REG_WR  out  1  one-cycle register write strobe
- REG_RD  out  1  one-cycle register read strobe
- REG_SEL  out  NSEL  latched select, valid while REG_WR/REG_RD high
- REG_WDATA  out  16  latched write data
- REG_RDATA  in  16  register read data, valid RD_LAT cycles after REG_RD
- BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE.
  - DTACK_N=1, BERR_N=1, DATA_OE=0.
  - DATA_OUT=0, REG_WR=0, REG_RD=0, REG_SEL=0, REG_WDATA=0, BUSY=0.
  - Synchroniser flops reset to 1.
  - Reset mid-cycle releases DTACK_N/DATA_OE at the next edge and issues no further strobes.
- Strobe synchronisation:
  - AS_N, DS0_N, DS1_N each pass through SYNC_STAGES flops giving as_s, ds0_s, ds1_s.
  - ds_both = !ds0_s & !ds1_s; ds_none = ds0_s & ds1_s.
- IDLE: when !as_s & ds_both, go to DECODE. On that edge latch ADDR, SEL→sel_q, WRITE_N→wr_q and DATA_IN→REG_WDATA.
- DECODE (1 cycle):
  - If sel_q==0 or sel_q is not one-hot, go to NOMATCH.
  - Else if wr_q==0, go to WR; otherwise go to RD.
- WR (1 cycle): REG_WR=1 and REG_SEL=sel_q; then go to ACK.
- RD:
  - Lasts RD_LAT+1 cycles, counted by a 3-bit counter.
  - REG_RD=1 only in the first cycle.
  - On the exit edge, capture REG_RDATA→DATA_OUT and set DATA_OE=1; go to ACK.
- ACK: DTACK_N=0. Stay until ds_none, then go to RELEASE.
- RELEASE (1 cycle): DTACK_N=1 and DATA_OE=0, deasserted together; then go to IDLE.
- NOMATCH: no DTACK. Return to IDLE when ds_none.
- Latency, measured from the first edge sampling both DS low:
  - Write: DTACK_N falls after SYNC_STAGES+3 edges (default 5).
  - Read: DTACK_N falls after SYNC_STAGES+3+RD_LAT edges (default 6).
  - Release: DTACK_N rises SYNC_STAGES+1 edges after DS high is sampled.
- Single DS low (byte access) never enters DECODE; it is unsupported, so IDLE waits.
- AS rising (as_s=1) while in DECODE or NOMATCH: go to IDLE without strobes. A strobe already issued is never retracted.
- Back-to-back cycles: IDLE requires ds_none to have been seen since the last cycle, so there is no re-trigger on a held DS.
- Outputs are registered; no combinational path from VME inputs to outputs.

Optional Feature:
VME_BERR_EN:
- Defined:
  - NOMATCH drives BERR_N=0 until ds_none.
  - A byte access (exactly one DS low for 2 consecutive synchronised cycles with AS low) also enters NOMATCH.
- Undefined: BERR_N is constant 1 and unmatched cycles are left to the system bus timer.

Decomposition:
- Package vme_pkg holds:
  - state enum IDLE, DECODE, WR, RD, ACK, RELEASE, NOMATCH;
  - NSEL;
  - register address localparams 16'h7C80 … 16'h7CA4;
  - the one-hot check function.
- Sub-module vme_sync: parameterised N-stage reset-to-1 synchroniser, instantiated three times.

Test Plan:
- Write 0xA5A5 to 0x7C84 (SEL bit2):
  - REG_WR high exactly 1 cycle, REG_SEL=0x004, REG_WDATA=0xA5A5.
  - DTACK_N low after 5 edges; released 3 edges after DS high.
- Read 0x7CA2 with REG_RDATA=0x1234, RD_LAT=1: one REG_RD pulse, DATA_OUT=0x1234, DATA_OE=1 with DTACK_N low at edge 6; both drop on the same edge.
- Read 0x7C92 (SEL=0): no REG_RD/REG_WR, DTACK_N stays 1. With VME_BERR_EN, BERR_N=0 until DS release.
- DS0_N low only for 20 cycles: no strobes, no DTACK. With VME_BERR_EN, BERR_N asserted.
- RST pulsed while in ACK: next edge DTACK_N=1, DATA_OE=0, BUSY=0; a following normal write completes.
- DS held low after ACK for 50 cycles: DTACK_N held low 50 cycles, single REG_WR, no second cycle.
